// File: rtl/shift_sequencer_pkg.sv
// Shared constants for the MIPS shift sequencer: funct-derived op codes,
// FSM state encoding and default datapath widths.
package mips_shift_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int SHW_DEF   = 5;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result bundle between decode/control (master) and the shift
// sequencer (slave).
interface shift_sequencer_if
  import mips_shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
) ();

  logic             start;
  logic             kill;
  logic [1:0]       op;
  logic             var_sel;
  logic [SHW-1:0]   shamt;
  logic [SHW-1:0]   rs_lo;
  logic [WIDTH-1:0] data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] amt_ext;

  modport master (
    output start, kill, op, var_sel, shamt, rs_lo, data,
    input  busy, done, result, amt_ext
  );

  modport slave (
    input  start, kill, op, var_sel, shamt, rs_lo, data,
    output busy, done, result, amt_ext
  );

endinterface

// File: rtl/shift_sequencer_step.sv
// One-bit shift of the accumulator; sra replicates the sign bit, the
// reserved op code behaves as srl.
module shift_step
  import mips_shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] stepped
);

  always_comb begin
    stepped = {1'b0, acc[WIDTH-1:1]};
    case (op)
      OP_SLL:  stepped = {acc[WIDTH-2:0], 1'b0};
      OP_SRA:  stepped = {acc[WIDTH-1], acc[WIDTH-1:1]};
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: latches operand and amount on start, shifts
// one bit per clock, then pulses done for one cycle with the result.
module shift_sequencer
  import mips_shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  shift_sequencer_if.slave   bus
);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] result_reg;
  logic [SHW-1:0]   count_reg;
  logic [SHW-1:0]   amt_reg;
  logic [SHW-1:0]   amt_sel;
  logic [1:0]       op_reg;
  logic             accept;
  logic             last_step;

  assign amt_sel   = bus.var_sel ? bus.rs_lo : bus.shamt;
  assign accept    = (state_reg == IDLE) && bus.start && !bus.kill;
  assign last_step = (state_reg == SHIFT) && (count_reg == SHW'(1));

  shift_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc_reg),
    .op      (op_reg),
    .stepped (acc_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = (amt_sel == '0) ? DONE : SHIFT;
      SHIFT:   if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.kill) begin
      state_next = IDLE;
    end
  end

  // result is captured on the edge into DONE so a killed shift never
  // disturbs the previously reported value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg    <= '0;
      result_reg <= '0;
      count_reg  <= '0;
      amt_reg    <= '0;
      op_reg     <= OP_SLL;
    end else if (accept) begin
      acc_reg   <= bus.data;
      count_reg <= amt_sel;
      amt_reg   <= amt_sel;
      op_reg    <= bus.op;
      if (amt_sel == '0) begin
        result_reg <= bus.data;
      end
    end else if ((state_reg == SHIFT) && !bus.kill) begin
      acc_reg   <= acc_step;
      count_reg <= count_reg - SHW'(1);
      if (last_step) begin
        result_reg <= acc_step;
      end
    end
  end

  assign bus.busy    = (state_reg != IDLE);
  assign bus.done    = (state_reg == DONE);
  assign bus.result  = result_reg;
  assign bus.amt_ext = {{(WIDTH-SHW){1'b0}}, amt_reg};

endmodule
